pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 5, sets the number of in-order stages (index 0 = fetch, NUM_STAGES-1 = writeback); legal range 2..8.
REQ-002 Parameter CNT_W, default 32, sets the performance counter width.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 fetch_valid  input  1  stage 0 holds a valid instruction this cycle.
REQ-006 stall_req  input  NUM_STAGES  bit k: stage k cannot complete this cycle.
REQ-007 flush_req  input  NUM_STAGES  bit k: stage k redirects; all younger stages (index < k) are killed.
REQ-008 perf_clr  input  1  synchronous clear of all performance counters.
REQ-009 stage_valid  output  NUM_STAGES  effective valid per stage (valid and not killed).
REQ-010 pipe_ld  output  NUM_STAGES  bit k (k>=1): load enable of the pipeline register feeding stage k; bit 0 is PC load.
REQ-011 redirect_valid  output  1  a flush is honoured this cycle.
REQ-012 redirect_src  output  3  index of the honoured flushing stage; 0 when redirect_valid=0.
REQ-013 retire  output  1  writeback instruction completes this cycle.
REQ-014 retired_cnt, stall_cnt, flush_cnt  output  CNT_W each  performance counters.

Function
REQ-015 v[0] SHALL equal fetch_valid; v[k], k>=1, SHALL be the registered valid bit valid_q[k].
REQ-016 hold[N-1] SHALL equal v[N-1] & stall_req[N-1]; hold[k] SHALL equal v[k] & (stall_req[k] | hold[k+1]) for k<N-1, so empty stages absorb stalls (bubble collapse).
REQ-017 flush_req[j] SHALL be honoured iff v[j]=1; an invalid stage's flush request is ignored.
REQ-018 killed[k] SHALL be 1 iff some honoured flush exists at index j>k; kill overrides hold.
REQ-019 When several flushes are honoured, redirect_src SHALL be the highest (oldest) index.
REQ-020 Next state for k>=1: killed[k] -> valid_q[k]=0; else hold[k] -> unchanged; else valid_q[k] = v[k-1] & ~hold[k-1] & ~killed[k-1].
REQ-021 pipe_ld[k] SHALL equal ~hold[k] | killed[k] for all k, including k=0.
REQ-022 stage_valid[k] SHALL equal v[k] & ~killed[k], combinationally.
REQ-023 retire SHALL equal v[N-1] & ~hold[N-1].
REQ-024 All outputs except counters SHALL be combinational from inputs and valid_q; zero-cycle latency.

Reset
REQ-025 Reset assertion SHALL immediately clear all valid_q and counters, regardless of clock, including mid-flush or mid-stall.
REQ-026 Outputs during reset SHALL reflect valid_q=0 (stage_valid[0] still follows fetch_valid).

Configuration
REQ-027 Macro PIPE_CTRL_PERF_EN defined: retired_cnt increments on retire; stall_cnt on cycles with any hold[k]=1; flush_cnt on redirect_valid; all wrap modulo 2^CNT_W; perf_clr has priority over increment.
REQ-028 Macro undefined: counter ports SHALL remain and be tied to 0; no counter flops are instantiated; perf_clr is ignored.

Structure
REQ-029 Stage index constants (STG_IF=0 .. STG_WB=4) and default NUM_STAGES SHALL live in package rv32i_types.
REQ-030 Each counter SHALL be an instance of sub-module pipe_perf_cnt (CNT_W, inc, clr), generated only under PIPE_CTRL_PERF_EN.

Verification (NUM_STAGES=5, PERF enabled)
REQ-031 Reset release, fetch_valid=1, no stall/flush -> valid_q fills one stage per cycle; first retire on 4th edge after release; retired_cnt=1 one cycle later.
REQ-032 Full pipe, stall_req[3]=1 for 2 cycles -> pipe_ld=5'b10000, valid_q[4]=0 after first edge, stall_cnt=2.
REQ-033 Full pipe, flush_req[2]=1 one cycle -> stage_valid=5'b11100, redirect_src=2, pipe_ld[0]=1; next cycle valid_q[2:1]=0, valid_q[3]=1, flush_cnt=1.
REQ-034 flush_req[2] and flush_req[3] together, full pipe -> redirect_src=3, stage_valid[2]=0.
REQ-035 flush_req[3] with stall_req[1]=1 -> pipe_ld[1]=1, valid_q[1]=0 next cycle; flush_req[3] with v[3]=0 -> redirect_valid=0.
REQ-036 CNT_W=4, 16 retirements -> retired_cnt wraps to 0; rst low mid-run -> all valid_q and counters 0 before next edge.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline constants: stage indices, default depth and the
// priority encoder used to pick the oldest redirecting stage.
package rv32i_types;

  localparam int NUM_STAGES_DEF = 5;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  // Highest set bit wins: larger index means older instruction.
  function automatic logic [2:0] oldest_idx(input logic [7:0] vec);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (vec[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the pipeline datapath and its controller.
interface pipe_ctrl_if
  import rv32i_types::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int CNT_W      = 32
);

  logic                  fetch_valid;
  logic [NUM_STAGES-1:0] stall_req;
  logic [NUM_STAGES-1:0] flush_req;
  logic                  perf_clr;

  logic [NUM_STAGES-1:0] stage_valid;
  logic [NUM_STAGES-1:0] pipe_ld;
  logic                  redirect_valid;
  logic [2:0]            redirect_src;
  logic                  retire;
  logic [CNT_W-1:0]      retired_cnt;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output fetch_valid, stall_req, flush_req, perf_clr,
    input  stage_valid, pipe_ld, redirect_valid, redirect_src, retire,
    input  retired_cnt, stall_cnt, flush_cnt
  );

  modport slave (
    input  fetch_valid, stall_req, flush_req, perf_clr,
    output stage_valid, pipe_ld, redirect_valid, redirect_src, retire,
    output retired_cnt, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_perf_cnt.sv
// Wrapping event counter; a synchronous clear beats a same-cycle increment.
module pipe_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)      cnt_d = '0;
    else if (inc) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline valid/stall/flush controller with bubble collapse.
// Performance counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl
  import rv32i_types::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int CNT_W      = 32
) (
  input logic        clk,
  input logic        rst,
  pipe_ctrl_if.slave bus
);

  logic [NUM_STAGES-1:1] valid_q, valid_d;
  logic [NUM_STAGES-1:0] v, honoured, hold, killed;
  logic [7:0]            honoured_w;
  logic                  run_h, run_k;

  assign v        = {valid_q, bus.fetch_valid};
  assign honoured = bus.flush_req & v;

  // Walk from writeback toward fetch: stalls only propagate through
  // occupied stages, and a flush kills everything younger than itself.
  always_comb begin
    run_h  = 1'b0;
    run_k  = 1'b0;
    hold   = '0;
    killed = '0;
    for (int k = NUM_STAGES-1; k >= 0; k--) begin
      run_h     = v[k] & (bus.stall_req[k] | run_h);
      hold[k]   = run_h;
      killed[k] = run_k;
      run_k     = run_k | honoured[k];
    end
  end

  always_comb begin
    honoured_w                   = '0;
    honoured_w[NUM_STAGES-1:0]   = honoured;
  end

  always_comb begin
    valid_d = valid_q;
    for (int k = 1; k < NUM_STAGES; k++) begin
      if (killed[k])     valid_d[k] = 1'b0;
      else if (!hold[k]) valid_d[k] = v[k-1] & ~hold[k-1] & ~killed[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  assign bus.stage_valid    = v & ~killed;
  assign bus.pipe_ld        = ~hold | killed;
  assign bus.redirect_valid = |honoured;
  assign bus.redirect_src   = oldest_idx(honoured_w);
  assign bus.retire         = v[NUM_STAGES-1] & ~hold[NUM_STAGES-1];

`ifdef PIPE_CTRL_PERF_EN
  logic any_hold;
  assign any_hold = |hold;

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk(clk), .rst(rst), .inc(bus.retire), .clr(bus.perf_clr), .cnt(bus.retired_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk), .rst(rst), .inc(any_hold), .clr(bus.perf_clr), .cnt(bus.stall_cnt)
  );
  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk), .rst(rst), .inc(bus.redirect_valid), .clr(bus.perf_clr), .cnt(bus.flush_cnt)
  );
`else
  assign bus.retired_cnt = '0;
  assign bus.stall_cnt   = '0;
  assign bus.flush_cnt   = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios plus randomized traffic checked
// against a stage-occupancy reference model; counters follow PIPE_CTRL_PERF_EN.
module tb_pipe_ctrl;
  import rv32i_types::*;

  localparam int N = 5;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_ctrl_if #(.NUM_STAGES(N), .CNT_W(32)) bus ();
  pipe_ctrl_if #(.NUM_STAGES(N), .CNT_W(4))  bus4 ();

  assign bus4.fetch_valid = bus.fetch_valid;
  assign bus4.stall_req   = bus.stall_req;
  assign bus4.flush_req   = bus.flush_req;
  assign bus4.perf_clr    = bus.perf_clr;

  pipe_ctrl #(.NUM_STAGES(N), .CNT_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus.slave));
  pipe_ctrl #(.NUM_STAGES(N), .CNT_W(4))  dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  int total = 0;
  int bad   = 0;

  // Reference model state: occupancy of stages 1..N-1 plus event totals.
  bit          mv [N];
  logic [31:0] m_ret, m_stall, m_flush;
  logic [N-1:0] e_sv, e_ld;
  logic         e_rv, e_ret;
  logic [2:0]   e_rs;
  bit           e_hold_any;
  bit           e_nv [N];

  function automatic void model_eval();
    bit v [N];
    bit h [N];
    bit kl [N];
    int oldest;
    v[0] = bus.fetch_valid;
    for (int k = 1; k < N; k++) v[k] = mv[k];
    // A stage is stuck if a stalled stage sits at or ahead of it with no gap between.
    for (int k = 0; k < N; k++) begin
      h[k] = 1'b0;
      for (int j = k; j < N; j++) begin
        if (!v[j]) break;
        if (bus.stall_req[j]) begin h[k] = 1'b1; break; end
      end
    end
    oldest = -1;
    for (int j = N-1; j >= 0; j--) begin
      if (bus.flush_req[j] && v[j]) begin oldest = j; break; end
    end
    e_hold_any = 1'b0;
    for (int k = 0; k < N; k++) begin
      kl[k]      = (oldest > k);
      e_sv[k]    = v[k] && !kl[k];
      e_ld[k]    = !h[k] || kl[k];
      e_hold_any = e_hold_any || h[k];
    end
    e_rv  = (oldest >= 0);
    e_rs  = (oldest >= 0) ? 3'(oldest) : 3'd0;
    e_ret = v[N-1] && !h[N-1];
    e_nv[0] = 1'b0;
    for (int k = 1; k < N; k++)
      e_nv[k] = kl[k] ? 1'b0 : (h[k] ? v[k] : (v[k-1] && !h[k-1] && !kl[k-1]));
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N; k++) mv[k] = 1'b0;
    m_ret = '0; m_stall = '0; m_flush = '0;
  endfunction

  function automatic logic [31:0] exp_cnt(input logic [31:0] m);
    return PERF ? m : 32'd0;
  endfunction

  task automatic drive(input logic f, input logic [N-1:0] s, input logic [N-1:0] fl, input logic c);
    bus.fetch_valid = f;
    bus.stall_req   = s;
    bus.flush_req   = fl;
    bus.perf_clr    = c;
  endtask

  task automatic advance();
    model_eval();
    @(posedge clk);
    if (!rst) model_reset();
    else begin
      for (int k = 0; k < N; k++) mv[k] = e_nv[k];
      if (bus.perf_clr) begin
        m_ret = '0; m_stall = '0; m_flush = '0;
      end else begin
        if (e_ret)      m_ret   = m_ret + 1;
        if (e_hold_any) m_stall = m_stall + 1;
        if (e_rv)       m_flush = m_flush + 1;
      end
    end
    #1;
  endtask

  task automatic refill();
    drive(1'b1, '0, '0, 1'b0);
    repeat (4) advance();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    model_reset();
    #2;
    total++; if (bus.stage_valid !== 5'b00000) begin bad++; $display("FAIL rst_sv got=%b exp=%b", bus.stage_valid, 5'b00000); end
    total++; if (bus.pipe_ld !== 5'b11111) begin bad++; $display("FAIL rst_ld got=%b exp=%b", bus.pipe_ld, 5'b11111); end
    total++; if (bus.redirect_valid !== 1'b0 || bus.redirect_src !== 3'd0) begin bad++; $display("FAIL rst_redir got=%b/%0d exp=0/0", bus.redirect_valid, bus.redirect_src); end
    total++; if (bus.retire !== 1'b0) begin bad++; $display("FAIL rst_retire got=%b exp=0", bus.retire); end
    total++; if (bus.retired_cnt !== 32'd0 || bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d/%0d/%0d exp=0/0/0", bus.retired_cnt, bus.stall_cnt, bus.flush_cnt); end
    bus.fetch_valid = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.stage_valid !== 5'b00001) begin bad++; $display("FAIL rst_fetch_sv got=%b exp=%b", bus.stage_valid, 5'b00001); end
  endtask

  task automatic test_fill();
    logic [N-1:0] exp;
    rst = 1'b1;
    drive(1'b1, '0, '0, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      advance();
      exp = N'((1 << (c + 1)) - 1);
      total++; if (bus.stage_valid !== exp) begin bad++; $display("FAIL fill_sv%0d got=%b exp=%b", c, bus.stage_valid, exp); end
      total++; if (bus.retire !== (c == 4)) begin bad++; $display("FAIL fill_retire%0d got=%b exp=%b", c, bus.retire, (c == 4)); end
    end
    advance();
    total++; if (bus.retired_cnt !== exp_cnt(32'd1)) begin bad++; $display("FAIL fill_retcnt got=%0d exp=%0d", bus.retired_cnt, exp_cnt(32'd1)); end
  endtask

  task automatic test_stall();
    logic [31:0] s0;
    s0 = m_stall;
    drive(1'b1, N'(1 << STG_MEM), '0, 1'b0);
    #1;
    total++; if (bus.pipe_ld !== 5'b10000) begin bad++; $display("FAIL stall_ld got=%b exp=%b", bus.pipe_ld, 5'b10000); end
    advance();
    total++; if (bus.stage_valid !== 5'b01111) begin bad++; $display("FAIL stall_sv got=%b exp=%b", bus.stage_valid, 5'b01111); end
    total++; if (bus.pipe_ld !== 5'b10000) begin bad++; $display("FAIL stall_ld2 got=%b exp=%b", bus.pipe_ld, 5'b10000); end
    advance();
    total++; if (bus.stall_cnt !== exp_cnt(s0 + 32'd2)) begin bad++; $display("FAIL stall_cnt got=%0d exp=%0d", bus.stall_cnt, exp_cnt(s0 + 32'd2)); end
    drive(1'b1, '0, '0, 1'b0);
    advance();
  endtask

  task automatic test_flush();
    logic [31:0] f0;
    f0 = m_flush;
    drive(1'b1, '0, N'(1 << STG_EX), 1'b0);
    #1;
    total++; if (bus.stage_valid !== 5'b11100) begin bad++; $display("FAIL flush_sv got=%b exp=%b", bus.stage_valid, 5'b11100); end
    total++; if (bus.redirect_valid !== 1'b1 || bus.redirect_src !== 3'd2) begin bad++; $display("FAIL flush_redir got=%b/%0d exp=1/2", bus.redirect_valid, bus.redirect_src); end
    total++; if (bus.pipe_ld[0] !== 1'b1) begin bad++; $display("FAIL flush_pcld got=%b exp=1", bus.pipe_ld[0]); end
    advance();
    drive(1'b1, '0, '0, 1'b0);
    #1;
    total++; if (bus.stage_valid !== 5'b11001) begin bad++; $display("FAIL flush_after_sv got=%b exp=%b", bus.stage_valid, 5'b11001); end
    total++; if (bus.flush_cnt !== exp_cnt(f0 + 32'd1)) begin bad++; $display("FAIL flush_cnt got=%0d exp=%0d", bus.flush_cnt, exp_cnt(f0 + 32'd1)); end
  endtask

  task automatic test_multi_flush();
    refill();
    drive(1'b1, '0, 5'b01100, 1'b0);
    #1;
    total++; if (bus.redirect_src !== 3'd3) begin bad++; $display("FAIL mflush_src got=%0d exp=3", bus.redirect_src); end
    total++; if (bus.stage_valid !== 5'b11000) begin bad++; $display("FAIL mflush_sv got=%b exp=%b", bus.stage_valid, 5'b11000); end
    advance();
  endtask

  task automatic test_flush_stall();
    refill();
    drive(1'b1, 5'b00010, 5'b01000, 1'b0);
    #1;
    total++; if (bus.pipe_ld[1] !== 1'b1) begin bad++; $display("FAIL fstall_ld1 got=%b exp=1", bus.pipe_ld[1]); end
    advance();
    drive(1'b1, '0, '0, 1'b0);
    #1;
    total++; if (bus.stage_valid[1] !== 1'b0) begin bad++; $display("FAIL fstall_v1 got=%b exp=0", bus.stage_valid[1]); end
    drive(1'b1, '0, 5'b01000, 1'b0);
    #1;
    total++; if (bus.redirect_valid !== 1'b0) begin bad++; $display("FAIL fstall_ignored got=%b exp=0", bus.redirect_valid); end
    advance();
  endtask

  task automatic test_random();
    logic [31:0] er, es, ef;
    logic [3:0]  er4, es4, ef4;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 2) == 0) ? N'($urandom & $urandom) : '0,
            ($urandom_range(0, 4) == 0) ? N'($urandom & $urandom) : '0,
            1'($urandom_range(0, 30) == 0));
      #1;
      model_eval();
      er = exp_cnt(m_ret); es = exp_cnt(m_stall); ef = exp_cnt(m_flush);
      er4 = er[3:0]; es4 = es[3:0]; ef4 = ef[3:0];
      total++; if (bus.stage_valid !== e_sv) begin bad++; $display("FAIL rnd_sv c%0d got=%b exp=%b", i, bus.stage_valid, e_sv); end
      total++; if (bus.pipe_ld !== e_ld) begin bad++; $display("FAIL rnd_ld c%0d got=%b exp=%b", i, bus.pipe_ld, e_ld); end
      total++; if (bus.redirect_valid !== e_rv) begin bad++; $display("FAIL rnd_rv c%0d got=%b exp=%b", i, bus.redirect_valid, e_rv); end
      total++; if (bus.redirect_src !== e_rs) begin bad++; $display("FAIL rnd_rs c%0d got=%0d exp=%0d", i, bus.redirect_src, e_rs); end
      total++; if (bus.retire !== e_ret) begin bad++; $display("FAIL rnd_retire c%0d got=%b exp=%b", i, bus.retire, e_ret); end
      total++; if (bus.retired_cnt !== er) begin bad++; $display("FAIL rnd_retcnt c%0d got=%0d exp=%0d", i, bus.retired_cnt, er); end
      total++; if (bus.stall_cnt !== es) begin bad++; $display("FAIL rnd_stallcnt c%0d got=%0d exp=%0d", i, bus.stall_cnt, es); end
      total++; if (bus.flush_cnt !== ef) begin bad++; $display("FAIL rnd_flushcnt c%0d got=%0d exp=%0d", i, bus.flush_cnt, ef); end
      total++; if (bus4.retired_cnt !== er4 || bus4.stall_cnt !== es4 || bus4.flush_cnt !== ef4) begin
        bad++; $display("FAIL rnd_cnt4 c%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d", i, bus4.retired_cnt, bus4.stall_cnt, bus4.flush_cnt, er4, es4, ef4);
      end
      advance();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] er;
    logic [3:0]  er4;
    drive(1'b1, '0, '0, 1'b1);
    advance();
    drive(1'b1, '0, '0, 1'b0);
    for (int i = 0; i < 60 && m_ret != 32'd16; i++) advance();
    total++; if (m_ret !== 32'd16) begin bad++; $display("FAIL wrap_timeout got=%0d exp=16", m_ret); end
    er = exp_cnt(m_ret); er4 = er[3:0];
    total++; if (bus4.retired_cnt !== er4) begin bad++; $display("FAIL wrap_cnt4 got=%0d exp=%0d", bus4.retired_cnt, er4); end
    total++; if (bus.retired_cnt !== er) begin bad++; $display("FAIL wrap_cnt32 got=%0d exp=%0d", bus.retired_cnt, er); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 5'b00100, 5'b01000, 1'b0);
    advance();
    advance();
    rst = 1'b0;
    #2;
    model_reset();
    total++; if (bus.stage_valid !== 5'b00001) begin bad++; $display("FAIL mid_rst_sv got=%b exp=%b", bus.stage_valid, 5'b00001); end
    total++; if (bus.retire !== 1'b0) begin bad++; $display("FAIL mid_rst_retire got=%b exp=0", bus.retire); end
    total++; if (bus.retired_cnt !== 32'd0 || bus.stall_cnt !== 32'd0 || bus.flush_cnt !== 32'd0) begin bad++; $display("FAIL mid_rst_cnt got=%0d/%0d/%0d exp=0/0/0", bus.retired_cnt, bus.stall_cnt, bus.flush_cnt); end
    total++; if (bus4.retired_cnt !== 4'd0 || bus4.stall_cnt !== 4'd0 || bus4.flush_cnt !== 4'd0) begin bad++; $display("FAIL mid_rst_cnt4 got=%0d/%0d/%0d exp=0/0/0", bus4.retired_cnt, bus4.stall_cnt, bus4.flush_cnt); end
    advance();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0);
    advance();
    total++; if (bus.stage_valid !== 5'b00000) begin bad++; $display("FAIL post_rst_sv got=%b exp=%b", bus.stage_valid, 5'b00000); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_flush();
    test_multi_flush();
    test_flush_stall();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
